// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle fetch/decode/regread/execute/mem/writeback control for the 16-bit RISC core
module ctrl_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  input  logic [15:0] alu_result,
  input  logic        shdbranch,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] ir,
  output logic [4:0]  aluop,
  output logic [7:0]  imm,
  output logic        alu_en,
  output logic        rf_rd_en,
  output logic        rf_we,
  output logic        wb_sel,
  output logic [15:0] pc,
  output logic        halted,
  output logic [2:0]  state,
  output logic [15:0] mdr
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] FETCH     = 3'd1;
  localparam logic [2:0] DECODE    = 3'd2;
  localparam logic [2:0] REGREAD   = 3'd3;
  localparam logic [2:0] EXECUTE   = 3'd4;
  localparam logic [2:0] MEM       = 3'd5;
  localparam logic [2:0] WRITEBACK = 3'd6;
  localparam logic [2:0] HALT      = 3'd7;
  logic [3:0]  op;
  logic [2:0]  next_state;
  logic [15:0] addr_q;
  logic        br_q;
  assign op = ir[15:12];
  always_comb begin
    next_state = state == IDLE      ? FETCH :
                 state == FETCH     ? (mem_ready ? DECODE : FETCH) :
                 state == DECODE    ? (op == 4'd15 ? HALT : REGREAD) :
                 state == REGREAD   ? EXECUTE :
                 state == EXECUTE   ? (op == 4'd12 || op == 4'd13 ? MEM : WRITEBACK) :
                 state == MEM       ? (mem_ready ? WRITEBACK : MEM) :
                 state == WRITEBACK ? FETCH : HALT;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      ir     <= '0;
      addr_q <= '0;
      br_q   <= 1'b0;
      mdr    <= '0;
    end else begin
      state <= next_state;
      if (state == FETCH && mem_ready) ir <= mem_rdata;
      if (state == EXECUTE) begin
        addr_q <= alu_result;
        br_q   <= (op == 4'd10 || op == 4'd11) && shdbranch;
      end
      if (state == MEM && mem_ready) mdr <= mem_rdata;
      if (state == WRITEBACK) pc <= br_q ? addr_q : pc + 16'd1;
    end
  end
  assign mem_req  = state == FETCH || state == MEM;
  assign mem_we   = state == MEM && op == 4'd13;
  assign mem_addr = state == FETCH ? pc : state == MEM ? addr_q : 16'h0000;
  assign aluop    = op < 4'd12 ? ir[15:11] : 5'd0;
  assign imm      = ir[7:0];
  assign alu_en   = state == EXECUTE;
  assign rf_rd_en = state == REGREAD;
  assign rf_we    = state == WRITEBACK && (op < 4'd10 || op == 4'd12);
  assign wb_sel   = state == WRITEBACK && op == 4'd12;
  assign halted   = state == HALT;
endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Multi-cycle control sequencer for the 16-bit RISC core. Owns the program counter and instruction register, steps each instruction through fetch, decode, register read, execute, optional memory access and writeback, and drives the ALU enable, register-file strobes and a single shared memory port. Sits between the unified memory interface, the register file and the negedge-clocked ALU.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock. Controller registers update on the posedge; the ALU samples on the negedge.
- rst_n  in  1  synchronous reset, active-low.
- mem_ready  in  1  memory handshake; the access completes on any posedge where mem_ready=1 while mem_req=1.
- mem_rdata  in  16  read data; valid when mem_ready=1.
- alu_result  in  16  ALU result output.
- shdbranch  in  1  ALU branch flag.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write strobe; qualified by mem_req.
- mem_addr  out  16  pc during FETCH; latched ALU result during MEM.
- ir  out  16  instruction register.
- aluop  out  5  ALU operation.
- imm  out  8  ir[7:0].
- alu_en  out  1  ALU enable.
- rf_rd_en  out  1  register-file operand read strobe.
- rf_we  out  1  register-file write strobe.
- wb_sel  out  1  writeback source: 0 selects alu_result, 1 selects the latched mem_rdata.
- pc  out  16  program counter.
- halted  out  1  high in the HALT state.
- state  out  3  current state, for debug.

## Operation
- Opcode field: op = ir[15:12].
  - 0–11 are ALU operations.
  - 12 is LDM (load from memory).
  - 13 is STM (store to memory).
  - 14 is NOP.
  - 15 is HALT.
- aluop generation:
  - For op 0–11: aluop = ir[15:11].
  - For op 12–14: aluop = 5'b00000 (unsigned Add, used to compute the address).
- States and encodings: IDLE=0, FETCH=1, DECODE=2, REGREAD=3, EXECUTE=4, MEM=5, WRITEBACK=6, HALT=7.
- IDLE
  - All outputs 0.
  - Unconditionally → FETCH.
- FETCH
  - mem_req=1, mem_we=0, mem_addr=pc.
  - Holds while mem_ready=0.
  - On mem_ready=1: ir <= mem_rdata, → DECODE.
- DECODE
  - op=15 → HALT.
  - Otherwise → REGREAD.
- REGREAD
  - rf_rd_en=1.
  - → EXECUTE.
- EXECUTE
  - alu_en=1 for the whole cycle.
  - At the closing posedge:
    - addr_q <= alu_result.
    - br_q <= shdbranch only when op is 10 or 11; otherwise br_q <= 0.
  - The br_q masking is mandatory because the ALU holds a stale shdbranch.
  - op 12 or 13 → MEM; all other opcodes → WRITEBACK.
- MEM
  - mem_req=1, mem_addr=addr_q, mem_we=(op==13).
  - Holds while mem_ready=0.
  - On mem_ready=1: mdr <= mem_rdata, → WRITEBACK.
- WRITEBACK
  - rf_we=1 for op 0–9 and op 12; rf_we=0 for op 10, 11, 13 and 14.
  - wb_sel=(op==12).
  - pc <= br_q ? addr_q : pc+1, with 16-bit wrap (16'hFFFF+1 = 16'h0000).
  - → FETCH.
- HALT
  - Sticky until reset.
  - halted=1; all other strobes 0; pc frozen.

## Timing
- Strobes (mem_req, mem_we, alu_en, rf_rd_en, rf_we, wb_sel, halted) are decoded from the registered state and are glitch-free at the posedge.
- rst_n=0 at a posedge applies reset from any state, including mid-handshake in FETCH or MEM:
  - state=IDLE, pc=RESET_PC, ir=0, addr_q=0, br_q=0, mdr=0.
  - All strobes are 0 from that edge on.
  - The first FETCH begins one cycle after rst_n returns high.
- The ALU sees alu_en=1 at the negedge inside EXECUTE. Its result and shdbranch are stable before the closing posedge.
- Operand stability: register-file outputs and aluop must stay stable from REGREAD through EXECUTE. ir changes only at the FETCH completion edge.
- Latency with zero-wait memory (mem_ready tied high):
  - ALU op, jump or NOP: 5 cycles.
  - LDM or STM: 6 cycles.
  - HALT: 2 cycles to reach HALT.
- Each mem_ready=0 cycle adds one cycle to the current FETCH or MEM state.
- mem_ready seen outside FETCH/MEM is ignored.
- pc changes only at the posedge that leaves WRITEBACK.

## Test plan
- Reset check:
  - Stimulus: rst_n low for 2 cycles, then release.
  - Required: pc=RESET_PC and all strobes 0 while reset is applied; IDLE for 1 cycle after release; FETCH with mem_addr=0x0000 on the next cycle.
- ALU op, zero-wait:
  - Stimulus: memory returns Add (op 0) at pc=0x0000, mem_ready high.
  - Required: alu_en high exactly in cycle 4; rf_we=1, wb_sel=0 in cycle 5; pc=0x0001 and FETCH in cycle 6.
- LDM with wait states:
  - Stimulus: LDM with alu_result=0x0040; mem_ready low for 3 cycles in MEM.
  - Required: mem_addr=0x0040 with mem_we=0 held for 4 cycles; then rf_we=1, wb_sel=1 with the latched data.
- STM:
  - Stimulus: STM instruction.
  - Required: mem_we=1 only in the MEM state; rf_we=0 in WRITEBACK; pc increments.
- Branch masking:
  - Stimulus 1: JMPR with shdbranch=1 and alu_result=0x1234. Required: pc=0x1234.
  - Stimulus 2: then an Add while shdbranch is still 1. Required: pc increments to 0x1235.
- Corner cases:
  - Stimulus: HALT at pc=0xFFFF; also a NOP at pc=0xFFFF; also rst_n low during the MEM wait.
  - Required:
    - HALT sets halted=1 and leaves pc frozen at 0xFFFF.
    - NOP wraps pc to 0x0000.
    - Reset during the MEM wait drops mem_req at the reset edge.
